// File: rtl/distortion_pkg.sv
// Shared constants for the multimode distortion stage: clip mode encodings,
// the soft-knee compression shift and the clip-event counter width.
package distortion_pkg;

  typedef enum logic [1:0] {
    MODE_HARD = 2'd0,
    MODE_ASYM = 2'd1,
    MODE_SOFT = 2'd2,
    MODE_FUZZ = 2'd3
  } clip_mode_e;

  // Above the knee, the excess over threshold is divided by 2^SOFT_SHIFT.
  localparam int unsigned SOFT_SHIFT = 2;

  localparam int unsigned CLIP_CNT_W = 16;

endpackage

// File: rtl/distortion_multimode_core.sv
// dist_channel_core: combinational clip, gain and saturate for one channel.
// Returns the processed sample and a flag set when the input magnitude
// exceeds the threshold or the gain stage saturated.
module dist_channel_core
  import distortion_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int GAIN_W     = 3
) (
  input  logic [DATA_WIDTH-1:0] x,
  input  logic [1:0]            mode,
  input  logic [DATA_WIDTH-2:0] threshold,
  input  logic [GAIN_W-1:0]     gain_shift,
  output logic [DATA_WIDTH-1:0] y,
  output logic                  clip
);

  // Wide enough to hold the largest possible left shift without losing bits.
  localparam int SW = DATA_WIDTH + (1 << GAIN_W) - 1;

  logic                  neg;
  logic [DATA_WIDTH-1:0] neg_x;
  logic [DATA_WIDTH-2:0] mag;
  logic [DATA_WIDTH-2:0] t_half;
  logic [DATA_WIDTH-2:0] knee;
  logic [DATA_WIDTH-1:0] t_ext;
  logic                  over;
  logic [DATA_WIDTH-1:0] clipped;
  logic [SW-1:0]         shifted;
  logic                  sat;

  // Magnitude (most negative input saturates), clip per mode, then gain.
  always_comb begin
    neg   = x[DATA_WIDTH-1];
    neg_x = -x;
    if (!neg)
      mag = x[DATA_WIDTH-2:0];
    else if (x[DATA_WIDTH-2:0] == '0)
      mag = '1;
    else
      mag = neg_x[DATA_WIDTH-2:0];

    over   = (mag > threshold);
    t_half = threshold >> 1;
    knee   = threshold + ((mag - threshold) >> SOFT_SHIFT);
    t_ext  = {1'b0, threshold};

    case (clip_mode_e'(mode))
      MODE_HARD: clipped = over ? (neg ? -t_ext : t_ext) : x;
      MODE_ASYM: begin
        if (!neg)
          clipped = over ? t_ext : x;
        else
          clipped = (mag > t_half) ? -{1'b0, t_half} : x;
      end
      MODE_SOFT: clipped = over ? (neg ? -{1'b0, knee} : {1'b0, knee}) : x;
      MODE_FUZZ: clipped = over ? t_ext : {1'b0, mag};
      default:   clipped = x;
    endcase

    // A zero threshold silences every mode, including the soft knee.
    if (threshold == '0)
      clipped = '0;

    shifted = {{(SW-DATA_WIDTH){clipped[DATA_WIDTH-1]}}, clipped} << gain_shift;
    // Result fits only if all bits from the output sign bit upward agree.
    sat = !((&shifted[SW-1:DATA_WIDTH-1]) || (~|shifted[SW-1:DATA_WIDTH-1]));

    if (sat)
      y = shifted[SW-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    else
      y = shifted[DATA_WIDTH-1:0];

    clip = over | sat;
  end

endmodule

// File: rtl/distortion_multimode.sv
// distortion_multimode: two-stage multi-channel distortion with clip
// indicator and peak-hold timer. Stage 1 captures samples and configuration
// on audio_ready; stage 2 registers the processed output.
// Optional clip-event counter enabled by defining DISTORTION_CLIP_CNT_EN.
module distortion_multimode
  import distortion_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int CHANNELS     = 2,
  parameter int GAIN_W       = 3,
  parameter int HOLD_SAMPLES = 4800
) (
  input  logic                           CLK,
  input  logic                           rst,
  input  logic                           en,
  input  logic                           audio_ready,
  input  logic [CHANNELS*DATA_WIDTH-1:0] x,
  input  logic [1:0]                     mode,
  input  logic [DATA_WIDTH-2:0]          threshold,
  input  logic [GAIN_W-1:0]              gain_shift,
`ifdef DISTORTION_CLIP_CNT_EN
  input  logic                           clip_cnt_clr,
  output logic [CLIP_CNT_W-1:0]          clip_cnt,
`endif
  output logic [CHANNELS*DATA_WIDTH-1:0] y,
  output logic                           y_valid,
  output logic                           indicator
);

  localparam int HOLD_W = $clog2(HOLD_SAMPLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_SAMPLES);

  logic                           s1_valid;
  logic [CHANNELS*DATA_WIDTH-1:0] s1_x;
  logic                           s1_en;
  logic [1:0]                     s1_mode;
  logic [DATA_WIDTH-2:0]          s1_thr;
  logic [GAIN_W-1:0]              s1_gain;

  logic [CHANNELS*DATA_WIDTH-1:0] core_y;
  logic [CHANNELS-1:0]            ch_clip;
  logic                           clip_any;
  logic [HOLD_W-1:0]              hold_cnt;
  logic [HOLD_W-1:0]              hold_nxt;

  genvar g;
  generate
    for (g = 0; g < CHANNELS; g++) begin : g_ch
      dist_channel_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .GAIN_W     (GAIN_W)
      ) u_core (
        .x          (s1_x[g*DATA_WIDTH +: DATA_WIDTH]),
        .mode       (s1_mode),
        .threshold  (s1_thr),
        .gain_shift (s1_gain),
        .y          (core_y[g*DATA_WIDTH +: DATA_WIDTH]),
        .clip       (ch_clip[g])
      );
    end
  endgenerate

  // Stage 1: capture sample and its configuration on each strobe.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_x     <= '0;
      s1_en    <= 1'b0;
      s1_mode  <= '0;
      s1_thr   <= '0;
      s1_gain  <= '0;
    end else begin
      s1_valid <= audio_ready;
      if (audio_ready) begin
        s1_x    <= x;
        s1_en   <= en;
        s1_mode <= mode;
        s1_thr  <= threshold;
        s1_gain <= gain_shift;
      end
    end
  end

  // Next hold count: bypass clears, clip reloads, otherwise count down.
  always_comb begin
    clip_any = s1_en & (|ch_clip);
    hold_nxt = hold_cnt;
    if (!s1_en)
      hold_nxt = '0;
    else if (clip_any)
      hold_nxt = HOLD_LOAD;
    else if (hold_cnt != '0)
      hold_nxt = hold_cnt - 1'b1;
  end

  // Stage 2: register output sample, strobe and hold counter together.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      y        <= '0;
      y_valid  <= 1'b0;
      hold_cnt <= '0;
    end else begin
      y_valid <= s1_valid;
      if (s1_valid) begin
        y        <= s1_en ? core_y : s1_x;
        hold_cnt <= hold_nxt;
      end
    end
  end

  assign indicator = (hold_cnt != '0);

`ifdef DISTORTION_CLIP_CNT_EN
  // Saturating clip-event count; clear takes priority over increment.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst)
      clip_cnt <= '0;
    else if (clip_cnt_clr)
      clip_cnt <= '0;
    else if (s1_valid && clip_any && (clip_cnt != '1))
      clip_cnt <= clip_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_distortion_multimode.sv
// Self-checking bench for distortion_multimode (DATA_WIDTH=32, CHANNELS=2,
// HOLD_SAMPLES=4). A sample-level arithmetic model feeds a timestamped
// queue; a negedge process compares the DUT every cycle.
module tb_distortion_multimode;

  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;
  localparam int HOLD = 4;
  localparam logic [30:0] T0 = 31'h01000000;

  logic        CLK = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        audio_ready = 1'b0;
  logic [63:0] x = '0;
  logic [1:0]  mode = '0;
  logic [30:0] threshold = '0;
  logic [2:0]  gain_shift = '0;
  logic [63:0] y;
  logic        y_valid;
  logic        indicator;
`ifdef DISTORTION_CLIP_CNT_EN
  logic        clip_cnt_clr = 1'b0;
  logic [15:0] clip_cnt;
`endif

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  distortion_multimode #(
    .DATA_WIDTH   (32),
    .CHANNELS     (2),
    .GAIN_W       (3),
    .HOLD_SAMPLES (HOLD)
  ) dut (
    .CLK          (CLK),
    .rst          (rst),
    .en           (en),
    .audio_ready  (audio_ready),
    .x            (x),
    .mode         (mode),
    .threshold    (threshold),
    .gain_shift   (gain_shift),
`ifdef DISTORTION_CLIP_CNT_EN
    .clip_cnt_clr (clip_cnt_clr),
    .clip_cnt     (clip_cnt),
`endif
    .y            (y),
    .y_valid      (y_valid),
    .indicator    (indicator)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // One channel straight from the clip rules, in plain signed arithmetic.
  function automatic void model_ch(input logic [31:0] xv, input int m, input longint t,
                                   input int g, output logic [31:0] o32, output bit clip);
    longint xl, a, o, k;
    bit sat;
    xl = longint'($signed(xv));
    if (xl == MINV) a = MAXV;
    else if (xl < 0) a = -xl;
    else a = xl;
    k = t + ((a - t) / 4);
    case (m)
      0: o = (a > t) ? ((xl < 0) ? -t : t) : xl;
      1: if (xl >= 0) o = (a > t) ? t : xl;
         else o = (a > t / 2) ? -(t / 2) : xl;
      2: o = (a > t) ? ((xl < 0) ? -k : k) : xl;
      default: o = (a < t) ? a : t;
    endcase
    if (t == 0) o = 0;
    o = o * (longint'(1) << g);
    sat = 1'b0;
    if (o > MAXV) begin o = MAXV; sat = 1'b1; end
    else if (o < MINV) begin o = MINV; sat = 1'b1; end
    o32 = o[31:0];
    clip = (a > t) || sat;
  endfunction

  typedef struct {
    int          due;
    logic [63:0] y;
    bit          ind;
  } exp_t;

  exp_t exp_q[$];
  int   hold_m = 0;

  // Model: each accepted sample yields an expected output one edge later.
  always @(posedge CLK) begin
    logic [31:0] o0, o1;
    bit c0, c1;
    exp_t e;
    cyc++;
    if (!rst) begin
      exp_q.delete();
      hold_m = 0;
    end else if (audio_ready) begin
      model_ch(x[31:0], int'(mode), longint'(threshold), int'(gain_shift), o0, c0);
      model_ch(x[63:32], int'(mode), longint'(threshold), int'(gain_shift), o1, c1);
      if (!en) begin
        e.y = x;
        hold_m = 0;
      end else begin
        e.y = {o1, o0};
        if (c0 || c1) hold_m = HOLD;
        else if (hold_m > 0) hold_m--;
      end
      e.ind = (hold_m != 0);
      e.due = cyc + 1;
      exp_q.push_back(e);
    end
  end

  logic [63:0] last_y = '0;
  bit          last_ind = 1'b0;

  // Compare DUT against the model on every cycle.
  always @(negedge CLK) begin
    exp_t e;
    if (!rst) begin
      chk("rst_y", y, 64'h0);
      chk("rst_valid", 64'(y_valid), 64'h0);
      chk("rst_ind", 64'(indicator), 64'h0);
      last_y = '0;
      last_ind = 1'b0;
    end else if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e = exp_q.pop_front();
      chk("sb_valid", 64'(y_valid), 64'h1);
      chk("sb_y", y, e.y);
      chk("sb_ind", 64'(indicator), 64'(e.ind));
      last_y = e.y;
      last_ind = e.ind;
    end else begin
      chk("idle_valid", 64'(y_valid), 64'h0);
      chk("idle_y", y, last_y);
      chk("idle_ind", 64'(indicator), 64'(last_ind));
    end
  end

  task automatic apply(input logic [31:0] c0, input logic [31:0] c1, input logic [1:0] m,
                       input logic [30:0] t, input logic [2:0] g, input logic e, input bit keep);
    x = {c1, c0};
    mode = m;
    threshold = t;
    gain_shift = g;
    en = e;
    audio_ready = 1'b1;
    @(posedge CLK);
    #1;
    if (!keep) audio_ready = 1'b0;
  endtask

  task automatic settle;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] o;
    bit c;

    // Pin the model with hand-derived values.
    model_ch(32'h02000000, 0, longint'(T0), 0, o, c); chk("m_hard", {o, 31'b0, c}, {32'h01000000, 32'h1});
    model_ch(32'hFE000000, 1, longint'(T0), 0, o, c); chk("m_asym", 64'(o), 64'hFF800000);
    model_ch(32'hFE000000, 3, longint'(T0), 0, o, c); chk("m_fuzz", 64'(o), 64'h01000000);
    model_ch(32'h01400000, 2, longint'(T0), 0, o, c); chk("m_soft_p", 64'(o), 64'h01100000);
    model_ch(32'hFEC00000, 2, longint'(T0), 0, o, c); chk("m_soft_n", 64'(o), 64'hFEF00000);
    model_ch(32'h01000000, 0, longint'(T0), 7, o, c); chk("m_sat_p", {o, 31'b0, c}, {32'h7FFFFFFF, 32'h1});
    model_ch(32'hFF000000, 0, longint'(T0), 7, o, c); chk("m_sat_n", 64'(o), 64'h80000000);
    model_ch(32'h80000000, 3, 64'h7FFFFFFF, 0, o, c); chk("m_minabs", 64'(o), 64'h7FFFFFFF);
    model_ch(32'h12345678, 2, 0, 0, o, c);            chk("m_t0", 64'(o), 64'h0);

    repeat (3) @(posedge CLK);
    #1;
    chk("reset_y", y, 64'h0);
    rst = 1'b1;

    // 1: hard clip
    apply(32'h02000000, 32'h00001000, 2'd0, T0, 3'd0, 1'b1, 0);
    settle();
    chk("t1_valid", 64'(y_valid), 64'h1);
    chk("t1_y", y, {32'h00001000, 32'h01000000});
    chk("t1_ind", 64'(indicator), 64'h1);
    // 2: asymmetric and fuzz
    apply(32'hFE000000, 32'h0, 2'd1, T0, 3'd0, 1'b1, 0);
    settle();
    chk("t2_asym", 64'(y[31:0]), 64'hFF800000);
    apply(32'hFE000000, 32'h0, 2'd3, T0, 3'd0, 1'b1, 0);
    settle();
    chk("t2_fuzz", 64'(y[31:0]), 64'h01000000);
    // 3: soft knee
    apply(32'h01400000, 32'hFEC00000, 2'd2, T0, 3'd0, 1'b1, 0);
    settle();
    chk("t3_soft", y, {32'hFEF00000, 32'h01100000});
    // 4: gain saturation
    apply(32'h01000000, 32'h0, 2'd0, T0, 3'd7, 1'b1, 0);
    settle();
    chk("t4_satp", 64'(y[31:0]), 64'h7FFFFFFF);
    chk("t4_ind", 64'(indicator), 64'h1);
    apply(32'hFF000000, 32'h0, 2'd0, T0, 3'd7, 1'b1, 0);
    settle();
    chk("t4_satn", 64'(y[31:0]), 64'h80000000);
    // 5: bypass, back-to-back
    for (int i = 0; i < 6; i++) begin
      apply(32'h12345678, 32'(i), 2'd0, T0, 3'd2, 1'b0, 1);
      if (i >= 1) begin
        chk("t5_valid", 64'(y_valid), 64'h1);
        chk("t5_y", y, {32'(i - 1), 32'h12345678});
        chk("t5_ind", 64'(indicator), 64'h0);
      end
    end
    audio_ready = 1'b0;
    repeat (3) settle();
    // Mixed configuration sweep, back-to-back, scoreboard-checked.
    for (int i = 0; i < 60; i++) begin
      logic [30:0] t;
      case (i % 5)
        0: t = 31'h0;
        1: t = T0;
        2: t = 31'h7FFFFFFF;
        3: t = 31'(($urandom() >> 1) & 32'h00FFFFFF);
        default: t = 31'h00000003;
      endcase
      apply((i % 7 == 0) ? 32'h80000000 : $urandom(), $urandom(), 2'(i % 4), t,
            3'($urandom_range(0, 7)), (i % 9 != 4), 1);
    end
    audio_ready = 1'b0;
    repeat (3) settle();
    // 6: hold timer and mid-stream reset
    apply(32'h02000000, 32'h0, 2'd0, T0, 3'd0, 1'b1, 0);
    settle();
    chk("t6_clip_ind", 64'(indicator), 64'h1);
    for (int i = 1; i <= 4; i++) begin
      apply(32'h00000100, 32'h0, 2'd0, T0, 3'd0, 1'b1, 0);
      settle();
      chk("t6_hold_ind", 64'(indicator), (i < 4) ? 64'h1 : 64'h0);
    end
    apply(32'h02000000, 32'h0, 2'd0, T0, 3'd0, 1'b1, 1);
    apply(32'h02000000, 32'h0, 2'd0, T0, 3'd0, 1'b1, 0);
    chk("t6_pre_ind", 64'(indicator), 64'h1);
    rst = 1'b0;
    #1;
    chk("t6_rst_y", y, 64'h0);
    chk("t6_rst_valid", 64'(y_valid), 64'h0);
    chk("t6_rst_ind", 64'(indicator), 64'h0);
    repeat (2) settle();
    rst = 1'b1;
    repeat (6) settle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
